pwm_deadband_gen: RTL

Complementary PWM generator, the drive side of the PWM link that the PWM verification monitor counts pulses on. It produces a high-side/low-side pair from a programmable period and duty, with a programmable dead band (`db`) between the two phases, and emits a pulse at each period boundary. It sits behind the PWM IP's APB/AHB register file, which supplies `period`, `duty`, `db` and `en`; `pwm_h` is the pin the monitor observes.

---
 rtl/pwm_deadband_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pwm_deadband_gen.sv
// Complementary PWM generator with period/duty shadowing and a programmable dead band.
// Define PWM_DEADBAND_EN to build the dead-band output stage; otherwise db is ignored.
module pwm_deadband_gen #(
   parameter int WIDTH = 16
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic             en,
   input  logic [WIDTH-1:0] period,
   input  logic [WIDTH-1:0] duty,
   input  logic [3:0]       db,
   output logic             pwm_h,
   output logic             pwm_l,
   output logic             period_end,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] period_s;
   logic [WIDTH-1:0] duty_s;
   logic             raw;
   logic             en_q;
   logic             wrap;

   assign wrap       = (cnt == period_s);
   assign period_end = en & wrap;

`ifdef PWM_DEADBAND_EN
   logic [3:0] db_s;
   logic       raw_d;
`else
   logic       unused_db;
   assign unused_db = ^db;
`endif

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         period_s <= '0;
         duty_s   <= '0;
         cnt      <= '0;
         raw      <= 1'b0;
         en_q     <= 1'b0;
`ifdef PWM_DEADBAND_EN
         db_s     <= '0;
         raw_d    <= 1'b0;
`endif
      end else begin
         // Shadows follow the inputs while idle and refresh only at the wrap count.
         if (!en || wrap) begin
            period_s <= period;
            duty_s   <= duty;
`ifdef PWM_DEADBAND_EN
            db_s     <= db;
`endif
         end
         if (!en || wrap)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
         raw  <= en & (cnt < duty_s);
         en_q <= en;
`ifdef PWM_DEADBAND_EN
         raw_d <= raw;
`endif
      end
   end

`ifdef PWM_DEADBAND_EN
   typedef enum logic {
      RUN,
      DEAD
   } state_t;

   state_t     state;
   logic [3:0] dead_cnt;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state    <= RUN;
         dead_cnt <= '0;
         pwm_h    <= 1'b0;
         pwm_l    <= 1'b0;
      end else if (!en || !en_q) begin
         state    <= RUN;
         dead_cnt <= '0;
         pwm_h    <= 1'b0;
         pwm_l    <= 1'b0;
      end else if ((raw != raw_d) && (db_s != '0)) begin
         state    <= DEAD;
         dead_cnt <= db_s;
         pwm_h    <= 1'b0;
         pwm_l    <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               pwm_h <= raw;
               pwm_l <= ~raw;
            end
            DEAD: begin
               // Low side releases as the counter hits zero; high side waits one more cycle.
               if (dead_cnt > 4'd1) begin
                  dead_cnt <= dead_cnt - 1'b1;
               end else if (dead_cnt == 4'd1) begin
                  dead_cnt <= '0;
                  if (!raw) begin
                     state <= RUN;
                     pwm_l <= 1'b1;
                  end
               end else begin
                  state <= RUN;
                  pwm_h <= raw;
                  pwm_l <= ~raw;
               end
            end
            default: begin
               state <= RUN;
               pwm_h <= 1'b0;
               pwm_l <= 1'b0;
            end
         endcase
      end
   end
`else
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         pwm_h <= 1'b0;
         pwm_l <= 1'b0;
      end else if (!en) begin
         pwm_h <= 1'b0;
         pwm_l <= 1'b0;
      end else begin
         pwm_h <= raw;
         pwm_l <= ~raw & en_q;
      end
   end
`endif

endmodule
